// File: rtl/if_id_reg.sv
// IF/ID pipeline register for the five-stage MIPS core.
// Captures the fetch-stage PC, instruction word and fetch address error.
// Tags branch-delay-slot instructions. Inserts bubbles on exception entry
// (Req), on eret, and holds its contents on a hazard stall.
// Every output is driven directly from a register, so there is no
// combinational input-to-output path.
module if_id_reg #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Req,
   input  logic        stall,
   input  logic        ID_eret,
   input  logic        ID_jump,
   input  logic [31:0] EPC,
   input  logic [31:0] IF_PC,
   input  logic [31:0] IF_Instr,
   input  logic        IF_EXC_AdEL,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_Instr,
   output logic [4:0]  ID_ExcCode,
   output logic        ID_BD,
   output logic        ID_valid,
   output logic [31:0] fetch_cnt
);

   // ---- IF -> ID stage boundary ----
   logic [31:0] pc_p1;
   logic [31:0] instr_p1;
   logic [4:0]  exc_p1;
   logic        bd_p1;
   logic        vld_p1;
   logic [31:0] fetch_cnt_p1;

   // Update priority: reset, exception flush, stall hold, eret kill, normal capture.
   // Bubbles carry a real PC (handler or EPC) so an interrupt taken while a
   // bubble sits in ID still records a meaningful EPC.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc_p1        <= RESET_PC;
         instr_p1     <= 32'd0;
         exc_p1       <= 5'd0;
         bd_p1        <= 1'b0;
         vld_p1       <= 1'b0;
         fetch_cnt_p1 <= 32'd0;
      end else if (Req) begin
         pc_p1    <= HANDLER_PC;
         instr_p1 <= 32'd0;
         exc_p1   <= 5'd0;
         bd_p1    <= 1'b0;
         vld_p1   <= 1'b0;
      end else if (stall) begin
         // Hold everything; a jump stalled in ID tags its delay slot on release.
         pc_p1        <= pc_p1;
         instr_p1     <= instr_p1;
         exc_p1       <= exc_p1;
         bd_p1        <= bd_p1;
         vld_p1       <= vld_p1;
         fetch_cnt_p1 <= fetch_cnt_p1;
      end else if (ID_eret) begin
         // eret has no delay slot: discard whatever IF fetched.
         pc_p1    <= EPC;
         instr_p1 <= 32'd0;
         exc_p1   <= 5'd0;
         bd_p1    <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         // A faulting fetch is still a valid slot so CP0 sees its PC and BD.
         pc_p1        <= IF_PC;
         instr_p1     <= IF_EXC_AdEL ? 32'd0 : IF_Instr;
         exc_p1       <= IF_EXC_AdEL ? EXC_ADEL : 5'd0;
         bd_p1        <= ID_jump;
         vld_p1       <= 1'b1;
         fetch_cnt_p1 <= fetch_cnt_p1 + 32'd1;
      end
   end

   assign ID_PC      = pc_p1;
   assign ID_Instr   = instr_p1;
   assign ID_ExcCode = exc_p1;
   assign ID_BD      = bd_p1;
   assign ID_valid   = vld_p1;
   assign fetch_cnt  = fetch_cnt_p1;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed testbench for if_id_reg: linear sequence of steps with
// hand-computed expected values checked by immediate assertions.
module tb_if_id_reg;

   logic        CLK;
   logic        Reset;
   logic        Req;
   logic        stall;
   logic        ID_eret;
   logic        ID_jump;
   logic [31:0] EPC;
   logic [31:0] IF_PC;
   logic [31:0] IF_Instr;
   logic        IF_EXC_AdEL;
   logic [31:0] ID_PC;
   logic [31:0] ID_Instr;
   logic [4:0]  ID_ExcCode;
   logic        ID_BD;
   logic        ID_valid;
   logic [31:0] fetch_cnt;

   int total;
   int bad;

   if_id_reg dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .Req        (Req),
      .stall      (stall),
      .ID_eret    (ID_eret),
      .ID_jump    (ID_jump),
      .EPC        (EPC),
      .IF_PC      (IF_PC),
      .IF_Instr   (IF_Instr),
      .IF_EXC_AdEL(IF_EXC_AdEL),
      .ID_PC      (ID_PC),
      .ID_Instr   (ID_Instr),
      .ID_ExcCode (ID_ExcCode),
      .ID_BD      (ID_BD),
      .ID_valid   (ID_valid),
      .fetch_cnt  (fetch_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One clock edge, then sample 1 time unit later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the full ID-side state in one call.
   task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] exc, input logic bd, input logic vld,
                          input logic [31:0] cnt);
      chk({tag, ".pc"},    ID_PC, pc);
      chk({tag, ".instr"}, ID_Instr, instr);
      chk({tag, ".exc"},   {27'd0, ID_ExcCode}, {27'd0, exc});
      chk({tag, ".bd"},    {31'd0, ID_BD}, {31'd0, bd});
      chk({tag, ".valid"}, {31'd0, ID_valid}, {31'd0, vld});
      chk({tag, ".cnt"},   fetch_cnt, cnt);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      Reset = 1'b1; Req = 1'b0; stall = 1'b0; ID_eret = 1'b0; ID_jump = 1'b0;
      EPC = 32'h0; IF_PC = 32'h0000_1111; IF_Instr = 32'hAAAA_5555; IF_EXC_AdEL = 1'b0;

      // Reset state
      step();
      chk_all("reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);

      // Three normal fetches
      Reset = 1'b0; IF_PC = 32'h3000; IF_Instr = 32'h3C01_1234;
      step();
      chk_all("fetch0", 32'h3000, 32'h3C01_1234, 5'd0, 1'b0, 1'b1, 32'd1);
      IF_PC = 32'h3004; IF_Instr = 32'h3421_0001;
      step();
      chk_all("fetch1", 32'h3004, 32'h3421_0001, 5'd0, 1'b0, 1'b1, 32'd2);

      // Stall hold for two cycles while IF changes
      stall = 1'b1; IF_PC = 32'h3008; IF_Instr = 32'hDEAD_BEEF;
      step();
      chk_all("stall1", 32'h3004, 32'h3421_0001, 5'd0, 1'b0, 1'b1, 32'd2);
      IF_PC = 32'h300C; IF_Instr = 32'hCAFE_F00D;
      step();
      chk_all("stall2", 32'h3004, 32'h3421_0001, 5'd0, 1'b0, 1'b1, 32'd2);
      stall = 1'b0; IF_PC = 32'h3008; IF_Instr = 32'h0000_0000;
      step();
      chk_all("fetch2", 32'h3008, 32'h0, 5'd0, 1'b0, 1'b1, 32'd3);

      // Delay slot tagging, unstalled
      ID_jump = 1'b1; IF_PC = 32'h3010; IF_Instr = 32'h2002_0005;
      step();
      chk_all("ds_tag", 32'h3010, 32'h2002_0005, 5'd0, 1'b1, 1'b1, 32'd4);
      ID_jump = 1'b0; IF_PC = 32'h3014; IF_Instr = 32'h2003_0006;
      step();
      chk_all("ds_next", 32'h3014, 32'h2003_0006, 5'd0, 1'b0, 1'b1, 32'd5);

      // Delay slot tagging after one stall cycle
      ID_jump = 1'b1; stall = 1'b1; IF_PC = 32'h3010; IF_Instr = 32'h2002_0005;
      step();
      chk_all("ds_stall", 32'h3014, 32'h2003_0006, 5'd0, 1'b0, 1'b1, 32'd5);
      stall = 1'b0;
      step();
      chk_all("ds_tag2", 32'h3010, 32'h2002_0005, 5'd0, 1'b1, 1'b1, 32'd6);
      ID_jump = 1'b0; IF_PC = 32'h3014; IF_Instr = 32'h2003_0006;
      step();
      chk_all("ds_next2", 32'h3014, 32'h2003_0006, 5'd0, 1'b0, 1'b1, 32'd7);

      // AdEL fetch, in a delay slot
      ID_jump = 1'b1; IF_PC = 32'h3002; IF_Instr = 32'hFFFF_FFFF; IF_EXC_AdEL = 1'b1;
      step();
      chk_all("adel", 32'h3002, 32'h0, 5'd4, 1'b1, 1'b1, 32'd8);
      ID_jump = 1'b0; IF_EXC_AdEL = 1'b0; IF_PC = 32'h3018; IF_Instr = 32'h1111_1111;
      step();
      chk_all("after_adel", 32'h3018, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 32'd9);

      // Req overrides stall
      Req = 1'b1; stall = 1'b1; ID_jump = 1'b1; IF_PC = 32'h301C; IF_Instr = 32'h9999_9999;
      step();
      chk_all("req_stall", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0, 32'd9);
      Req = 1'b0; stall = 1'b0; ID_jump = 1'b0; IF_PC = 32'h4180; IF_Instr = 32'h2222_2222;
      step();
      chk_all("handler", 32'h4180, 32'h2222_2222, 5'd0, 1'b0, 1'b1, 32'd10);

      // eret kills IF
      ID_eret = 1'b1; EPC = 32'h3020; IF_PC = 32'h3104; IF_Instr = 32'h3333_3333;
      step();
      chk_all("eret", 32'h3020, 32'h0, 5'd0, 1'b0, 1'b0, 32'd10);
      ID_eret = 1'b0; IF_PC = 32'h3020; IF_Instr = 32'h4444_4444;
      step();
      chk_all("post_eret", 32'h3020, 32'h4444_4444, 5'd0, 1'b0, 1'b1, 32'd11);

      // eret with stall holds, then kills on release
      ID_eret = 1'b1; stall = 1'b1; EPC = 32'h3030; IF_PC = 32'h3024; IF_Instr = 32'h5555_5555;
      step();
      chk_all("eret_stall", 32'h3020, 32'h4444_4444, 5'd0, 1'b0, 1'b1, 32'd11);
      stall = 1'b0;
      step();
      chk_all("eret_rel", 32'h3030, 32'h0, 5'd0, 1'b0, 1'b0, 32'd11);

      // Illegal eret+jump: eret rule wins
      ID_jump = 1'b1; EPC = 32'h3040;
      step();
      chk_all("eret_jump", 32'h3040, 32'h0, 5'd0, 1'b0, 1'b0, 32'd11);
      ID_eret = 1'b0; ID_jump = 1'b0;

      // fetch_cnt wrap
      force dut.fetch_cnt_p1 = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_p1;
      chk("wrap_pre", fetch_cnt, 32'hFFFF_FFFF);
      IF_PC = 32'h3050; IF_Instr = 32'h6666_6666;
      step();
      chk_all("wrap", 32'h3050, 32'h6666_6666, 5'd0, 1'b0, 1'b1, 32'd0);
      IF_PC = 32'h3054; IF_Instr = 32'h7777_7777;
      step();
      chk("wrap_next", fetch_cnt, 32'd1);

      // Reset mid-operation beats Req and stall
      Reset = 1'b1; Req = 1'b1; stall = 1'b1;
      step();
      chk_all("reset_mid", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
